serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 158 +++++++++++++++
 tb/tb_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: computes a - b - bin over WIDTH/DIGIT cycles,
// LSB digit first, with optional clamp-to-zero on underflow.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             sat_q;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_step;
    logic [DIGIT-1:0] dig_d;
    logic             dig_br;
    logic [WIDTH-1:0] dig_ext;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] res_out;

    // Ripple-borrow over one digit; returns {borrow_out, difference}.
    function automatic logic [DIGIT:0] sub_digit(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             br_in
    );
        logic             br;
        logic [DIGIT-1:0] d;
        br = br_in;
        d  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & br) | (~x[i] & y[i]) | (y[i] & br);
        end
        return {br, d};
    endfunction

    function automatic logic [WIDTH-1:0] clamp_underflow(
        input logic [WIDTH-1:0] v,
        input logic             en,
        input logic             br
    );
        return (en && br) ? '0 : v;
    endfunction

    assign last_step = (cnt == LAST);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Current digit result is shifted in from the top so the LSB digit ends at bit 0.
    always_comb begin
        {dig_br, dig_d}      = sub_digit(a_sh[DIGIT-1:0], b_sh[DIGIT-1:0], borrow);
        dig_ext              = '0;
        dig_ext[DIGIT-1:0]   = dig_d;
        res_nxt              = (res_sh >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
        res_out              = clamp_underflow(res_nxt, sat_q, dig_br);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control and delivered results; reset clears the abort path immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b1;
        end else if (accept) begin
            cnt    <= '0;
            borrow <= bin;
        end else if (state == RUN) begin
            cnt    <= cnt + 1'b1;
            borrow <= dig_br;
            if (last_step) begin
                diff <= res_out;
                bout <= dig_br;
                zero <= (res_out == '0);
            end
        end
    end

    // Operand shift registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sat_q  <= sat;
            res_sh <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            res_sh <= res_nxt;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at three parameterisations sharing one clock and reset.
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        bin_in;
    logic        sat_in;

    logic        busy8, done8, bout8, zero8;
    logic [7:0]  diff8;
    logic        busy16, done16, bout16, zero16;
    logic [15:0] diff16;
    logic        busy4, done4, bout4, zero4;
    logic [3:0]  diff4;

    int          sel;
    logic        obs_busy, obs_done, obs_bout, obs_zero;
    logic [15:0] obs_diff;

    int n_checks;
    int n_pass;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in), .sat(sat_in),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(a_in), .b(b_in), .bin(bin_in), .sat(sat_in),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .zero(zero16)
    );

    serial_subtractor #(.WIDTH(4), .DIGIT(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a(a_in[3:0]), .b(b_in[3:0]), .bin(bin_in), .sat(sat_in),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
    );

    always_comb begin
        obs_busy = busy8;
        obs_done = done8;
        obs_diff = {8'h00, diff8};
        obs_bout = bout8;
        obs_zero = zero8;
        case (sel)
            1: begin
                obs_busy = busy16;
                obs_done = done16;
                obs_diff = diff16;
                obs_bout = bout16;
                obs_zero = zero16;
            end
            2: begin
                obs_busy = busy4;
                obs_done = done4;
                obs_diff = {12'h000, diff4};
                obs_bout = bout4;
                obs_zero = zero4;
            end
            default: ;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One operation on instance s, start pulsed for one cycle; returns in the done cycle.
    task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input logic sa, input logic [15:0] exp_diff,
                          input logic exp_bout, input int n, input bit disturb,
                          input string tag);
        int          cyc;
        int          busy_cnt;
        int          hold_err;
        logic [15:0] prev;
        sel = s;
        @(negedge clk);
        prev       = obs_diff;
        a_in       = a;
        b_in       = b;
        bin_in     = bi;
        sat_in     = sa;
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        hold_err = 0;
        while (!obs_done && cyc < 200) begin
            if (obs_busy) busy_cnt++;
            if (obs_diff !== prev) hold_err++;
            if (disturb && cyc == 3) begin
                start_v[s] = 1'b1;
                a_in       = ~a;
                b_in       = 16'h0002;
                bin_in     = ~bi;
                sat_in     = ~sa;
            end else if (disturb && cyc == 4) begin
                start_v[s] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_cycle"}, cyc, n + 1);
        check({tag, "_busy_cycles"}, busy_cnt, n);
        check({tag, "_diff_hold"}, hold_err, 0);
        check({tag, "_busy_at_done"}, obs_busy, 1'b0);
        check({tag, "_diff"}, obs_diff, exp_diff);
        check({tag, "_bout"}, obs_bout, exp_bout);
        check({tag, "_zero"}, obs_zero, exp_diff == 16'h0000);
    endtask

    initial begin
        int cyc;
        int hold;
        int seen;
        int exp_d;
        logic exp_b;

        n_checks = 0;
        n_pass   = 0;
        sel      = 0;
        start_v  = 3'b000;
        a_in     = '0;
        b_in     = '0;
        bin_in   = 1'b0;
        sat_in   = 1'b0;
        rst_n    = 1'b1;

        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", obs_busy, 1'b0);
        check("reset_done", obs_done, 1'b0);
        check("reset_diff", obs_diff, 16'h0000);
        check("reset_bout", obs_bout, 1'b0);
        check("reset_zero", obs_zero, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 16'h05, 16'h03, 1'b0, 1'b0, 16'h02, 1'b0, 8, 1'b0, "basic");
        repeat (3) @(negedge clk);
        check("held_diff", obs_diff, 16'h02);
        check("held_done", obs_done, 1'b0);

        run_op(0, 16'h00, 16'h01, 1'b0, 1'b0, 16'hFF, 1'b1, 8, 1'b0, "wrap");
        run_op(0, 16'h00, 16'h01, 1'b0, 1'b1, 16'h00, 1'b1, 8, 1'b0, "sat");
        run_op(0, 16'h00, 16'h00, 1'b1, 1'b0, 16'hFF, 1'b1, 8, 1'b0, "bin_wrap");
        run_op(0, 16'h80, 16'h7F, 1'b1, 1'b0, 16'h00, 1'b0, 8, 1'b0, "bin_zero");
        run_op(0, 16'h30, 16'h10, 1'b0, 1'b0, 16'h20, 1'b0, 8, 1'b1, "busy_ignore");

        // Back-to-back: start held high across the DONE cycle.
        sel = 0;
        @(negedge clk);
        a_in       = 16'h10;
        b_in       = 16'h01;
        bin_in     = 1'b0;
        sat_in     = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!obs_done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first_cycle", cyc, 9);
        check("b2b_first_diff", obs_diff, 16'h0F);
        a_in = 16'h23;
        b_in = 16'h02;
        @(negedge clk);
        cyc  = 1;
        hold = 0;
        while (!obs_done && cyc < 50) begin
            if (obs_diff !== 16'h0F) hold++;
            @(negedge clk);
            cyc++;
        end
        check("b2b_interval", cyc, 9);
        check("b2b_hold", hold, 0);
        check("b2b_second_diff", obs_diff, 16'h21);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("b2b_idle", {obs_busy, obs_done}, 2'b00);

        // Reset asserted in RUN cycle 4.
        a_in       = 16'h05;
        b_in       = 16'h03;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", obs_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", obs_busy, 1'b0);
        check("rst_mid_done", obs_done, 1'b0);
        check("rst_mid_diff", obs_diff, 16'h0000);
        check("rst_mid_bout", obs_bout, 1'b0);
        check("rst_mid_zero", obs_zero, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (15) begin
            @(negedge clk);
            if (obs_done || obs_busy) seen++;
        end
        check("rst_mid_no_done", seen, 0);

        run_op(1, 16'h1234, 16'h0235, 1'b0, 1'b0, 16'h0FFF, 1'b0, 4, 1'b0, "w16");
        run_op(1, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 4, 1'b0, "w16_sat");

        for (int ai = 0; ai < 16; ai++) begin
            for (int bj = 0; bj < 16; bj++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp_d = (ai - bj - ci) & 15;
                    exp_b = (ai < bj + ci);
                    run_op(2, 16'(ai), 16'(bj), ci[0], 1'b0, 16'(exp_d), exp_b, 2, 1'b0,
                           "w4_sweep");
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
